pif_reg_slice: RTL and testbench

PIF_REG_SLICE -- requirements
Module: pif_reg_slice

---
 rtl/pif_reg_slice.sv | 203 ++++++++++++++++++++
 tb/tb_pif_reg_slice.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pif_reg_slice.sv
// PIF register slice: independent request (M->S) and response (S->M) FIFOs, all outputs registered.
// Optional route-ID sideband payload is enabled by defining PIF_REG_SLICE_ROUTE_ID_EN.

module pif_reg_slice_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full, empty, push, pop;

  // Handshake signals decode only registered state, so no input reaches an output combinationally.
  assign full      = (cnt_q == CNT_W'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign in_ready  = en & ~full;
  assign out_valid = ~empty;
  assign out_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: stale entries are unreachable once occupancy is cleared.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

module pif_reg_slice #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ID_W      = 6,
  parameter int unsigned REQ_DEPTH = 2,
  parameter int unsigned RSP_DEPTH = 2,
  parameter int unsigned ROUTE_W   = 4
) (
  input  logic                CLK,
  input  logic                BResetN,
  input  logic                POReqValid_M,
  output logic                POReqValid_S,
  output logic                PIReqRdy_M,
  input  logic                PIReqRdy_S,
  input  logic [7:0]          POReqCntl_M,
  output logic [7:0]          POReqCntl_S,
  input  logic [31:0]         POReqAdrs_M,
  output logic [31:0]         POReqAdrs_S,
  input  logic [DATA_W-1:0]   POReqData_M,
  output logic [DATA_W-1:0]   POReqData_S,
  input  logic [DATA_W/8-1:0] POReqDataBE_M,
  output logic [DATA_W/8-1:0] POReqDataBE_S,
  input  logic [ID_W-1:0]     POReqId_M,
  output logic [ID_W-1:0]     POReqId_S,
  input  logic [1:0]          POReqPriority_M,
  output logic [1:0]          POReqPriority_S,
`ifdef PIF_REG_SLICE_ROUTE_ID_EN
  input  logic [ROUTE_W-1:0]  POReqRouteId_M,
  output logic [ROUTE_W-1:0]  POReqRouteId_S,
  input  logic [ROUTE_W-1:0]  PIRespRouteId_S,
  output logic [ROUTE_W-1:0]  PIRespRouteId_M,
`endif
  input  logic                PIRespValid_S,
  output logic                PIRespValid_M,
  input  logic                PORespRdy_M,
  output logic                PORespRdy_S,
  input  logic [7:0]          PIRespCntl_S,
  output logic [7:0]          PIRespCntl_M,
  input  logic [DATA_W-1:0]   PIRespData_S,
  output logic [DATA_W-1:0]   PIRespData_M,
  input  logic [ID_W-1:0]     PIRespId_S,
  output logic [ID_W-1:0]     PIRespId_M,
  input  logic [1:0]          PIRespPriority_S,
  output logic [1:0]          PIRespPriority_M
);

`ifdef PIF_REG_SLICE_ROUTE_ID_EN
  localparam bit ROUTE_EN = 1'b1;
`else
  localparam bit ROUTE_EN = 1'b0;
`endif
  localparam int unsigned ROUTE_BITS = ROUTE_EN ? ROUTE_W : 0;
  localparam int unsigned REQ_W = 8 + 32 + DATA_W + DATA_W/8 + ID_W + 2 + ROUTE_BITS;
  localparam int unsigned RSP_W = 8 + DATA_W + ID_W + 2 + ROUTE_BITS;

  if (DATA_W != 32 && DATA_W != 64 && DATA_W != 128) begin : g_bad_data_w
    $error("pif_reg_slice: DATA_W must be 32, 64 or 128");
  end
  if (REQ_DEPTH != 2 && REQ_DEPTH != 4 && REQ_DEPTH != 8 && REQ_DEPTH != 16) begin : g_bad_req_depth
    $error("pif_reg_slice: REQ_DEPTH must be 2, 4, 8 or 16");
  end
  if (RSP_DEPTH != 2 && RSP_DEPTH != 4 && RSP_DEPTH != 8 && RSP_DEPTH != 16) begin : g_bad_rsp_depth
    $error("pif_reg_slice: RSP_DEPTH must be 2, 4, 8 or 16");
  end

  logic             init_q, init_d;
  logic [REQ_W-1:0] req_in, req_out;
  logic [RSP_W-1:0] rsp_in, rsp_out;

  // Readies stay low through reset and rise on the first edge after release.
  always_comb begin
    init_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge BResetN) begin
    if (!BResetN) begin
      init_q <= 1'b0;
    end else begin
      init_q <= init_d;
    end
  end

`ifdef PIF_REG_SLICE_ROUTE_ID_EN
  assign req_in = {POReqCntl_M, POReqAdrs_M, POReqData_M, POReqDataBE_M,
                   POReqId_M, POReqPriority_M, POReqRouteId_M};
  assign {POReqCntl_S, POReqAdrs_S, POReqData_S, POReqDataBE_S,
          POReqId_S, POReqPriority_S, POReqRouteId_S} = req_out;
  assign rsp_in = {PIRespCntl_S, PIRespData_S, PIRespId_S, PIRespPriority_S, PIRespRouteId_S};
  assign {PIRespCntl_M, PIRespData_M, PIRespId_M, PIRespPriority_M, PIRespRouteId_M} = rsp_out;
`else
  assign req_in = {POReqCntl_M, POReqAdrs_M, POReqData_M, POReqDataBE_M,
                   POReqId_M, POReqPriority_M};
  assign {POReqCntl_S, POReqAdrs_S, POReqData_S, POReqDataBE_S,
          POReqId_S, POReqPriority_S} = req_out;
  assign rsp_in = {PIRespCntl_S, PIRespData_S, PIRespId_S, PIRespPriority_S};
  assign {PIRespCntl_M, PIRespData_M, PIRespId_M, PIRespPriority_M} = rsp_out;
`endif

  pif_reg_slice_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .clk       (CLK),
    .rst_n     (BResetN),
    .en        (init_q),
    .in_valid  (POReqValid_M),
    .in_data   (req_in),
    .in_ready  (PIReqRdy_M),
    .out_valid (POReqValid_S),
    .out_data  (req_out),
    .out_ready (PIReqRdy_S)
  );

  pif_reg_slice_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (CLK),
    .rst_n     (BResetN),
    .en        (init_q),
    .in_valid  (PIRespValid_S),
    .in_data   (rsp_in),
    .in_ready  (PORespRdy_S),
    .out_valid (PIRespValid_M),
    .out_data  (rsp_out),
    .out_ready (PORespRdy_M)
  );

endmodule

// File: tb/tb_pif_reg_slice.sv
// Scoreboard bench for pif_reg_slice: DATA_W=128, REQ_DEPTH=4, RSP_DEPTH=2.
module tb_pif_reg_slice;

  localparam int DW    = 128;
  localparam int REQ_D = 4;
  localparam int RSP_D = 2;

  typedef struct packed {
    logic [7:0]    cntl;
    logic [31:0]   adrs;
    logic [DW-1:0] data;
    logic [DW/8-1:0] be;
    logic [5:0]    id;
    logic [1:0]    pri;
    logic [3:0]    route;
  } req_t;

  typedef struct packed {
    logic [7:0]    cntl;
    logic [DW-1:0] data;
    logic [5:0]    id;
    logic [1:0]    pri;
    logic [3:0]    route;
  } rsp_t;

  logic CLK, BResetN;
  logic POReqValid_M, POReqValid_S, PIReqRdy_M, PIReqRdy_S;
  logic PIRespValid_S, PIRespValid_M, PORespRdy_M, PORespRdy_S;
  logic [7:0] POReqCntl_M, POReqCntl_S, PIRespCntl_S, PIRespCntl_M;
  logic [31:0] POReqAdrs_M, POReqAdrs_S;
  logic [DW-1:0] POReqData_M, POReqData_S, PIRespData_S, PIRespData_M;
  logic [DW/8-1:0] POReqDataBE_M, POReqDataBE_S;
  logic [5:0] POReqId_M, POReqId_S, PIRespId_S, PIRespId_M;
  logic [1:0] POReqPriority_M, POReqPriority_S, PIRespPriority_S, PIRespPriority_M;
`ifdef PIF_REG_SLICE_ROUTE_ID_EN
  logic [3:0] POReqRouteId_M, POReqRouteId_S, PIRespRouteId_S, PIRespRouteId_M;
`endif

  req_t req_in, req_obs;
  rsp_t rsp_in, rsp_obs;
  req_t req_q[$];
  rsp_t rsp_q[$];
  req_t req_prev;
  rsp_t rsp_prev;
  logic req_stall, rsp_stall, req_acc, rsp_acc, init_m;
  int   total, bad, n_rsp_out;

  assign POReqCntl_M     = req_in.cntl;
  assign POReqAdrs_M     = req_in.adrs;
  assign POReqData_M     = req_in.data;
  assign POReqDataBE_M   = req_in.be;
  assign POReqId_M       = req_in.id;
  assign POReqPriority_M = req_in.pri;
  assign PIRespCntl_S     = rsp_in.cntl;
  assign PIRespData_S     = rsp_in.data;
  assign PIRespId_S       = rsp_in.id;
  assign PIRespPriority_S = rsp_in.pri;
  assign req_obs.cntl = POReqCntl_S;
  assign req_obs.adrs = POReqAdrs_S;
  assign req_obs.data = POReqData_S;
  assign req_obs.be   = POReqDataBE_S;
  assign req_obs.id   = POReqId_S;
  assign req_obs.pri  = POReqPriority_S;
  assign rsp_obs.cntl = PIRespCntl_M;
  assign rsp_obs.data = PIRespData_M;
  assign rsp_obs.id   = PIRespId_M;
  assign rsp_obs.pri  = PIRespPriority_M;
`ifdef PIF_REG_SLICE_ROUTE_ID_EN
  assign POReqRouteId_M  = req_in.route;
  assign PIRespRouteId_S = rsp_in.route;
  assign req_obs.route   = POReqRouteId_S;
  assign rsp_obs.route   = PIRespRouteId_M;
`else
  assign req_obs.route = '0;
  assign rsp_obs.route = '0;
`endif

  pif_reg_slice #(
    .DATA_W    (DW),
    .ID_W      (6),
    .REQ_DEPTH (REQ_D),
    .RSP_DEPTH (RSP_D),
    .ROUTE_W   (4)
  ) dut (
    .CLK (CLK), .BResetN (BResetN),
    .POReqValid_M (POReqValid_M), .POReqValid_S (POReqValid_S),
    .PIReqRdy_M (PIReqRdy_M), .PIReqRdy_S (PIReqRdy_S),
    .POReqCntl_M (POReqCntl_M), .POReqCntl_S (POReqCntl_S),
    .POReqAdrs_M (POReqAdrs_M), .POReqAdrs_S (POReqAdrs_S),
    .POReqData_M (POReqData_M), .POReqData_S (POReqData_S),
    .POReqDataBE_M (POReqDataBE_M), .POReqDataBE_S (POReqDataBE_S),
    .POReqId_M (POReqId_M), .POReqId_S (POReqId_S),
    .POReqPriority_M (POReqPriority_M), .POReqPriority_S (POReqPriority_S),
`ifdef PIF_REG_SLICE_ROUTE_ID_EN
    .POReqRouteId_M (POReqRouteId_M), .POReqRouteId_S (POReqRouteId_S),
    .PIRespRouteId_S (PIRespRouteId_S), .PIRespRouteId_M (PIRespRouteId_M),
`endif
    .PIRespValid_S (PIRespValid_S), .PIRespValid_M (PIRespValid_M),
    .PORespRdy_M (PORespRdy_M), .PORespRdy_S (PORespRdy_S),
    .PIRespCntl_S (PIRespCntl_S), .PIRespCntl_M (PIRespCntl_M),
    .PIRespData_S (PIRespData_S), .PIRespData_M (PIRespData_M),
    .PIRespId_S (PIRespId_S), .PIRespId_M (PIRespId_M),
    .PIRespPriority_S (PIRespPriority_S), .PIRespPriority_M (PIRespPriority_M)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic req_t rnd_req();
    req_t r;
    r.cntl  = 8'($urandom);
    r.adrs  = $urandom;
    r.data  = {$urandom, $urandom, $urandom, $urandom};
    r.be    = 16'($urandom);
    r.id    = 6'($urandom);
    r.pri   = 2'($urandom);
`ifdef PIF_REG_SLICE_ROUTE_ID_EN
    r.route = 4'($urandom);
`else
    r.route = '0;
`endif
    return r;
  endfunction

  function automatic rsp_t rnd_rsp();
    rsp_t r;
    r.cntl  = 8'($urandom);
    r.data  = {$urandom, $urandom, $urandom, $urandom};
    r.id    = 6'($urandom);
    r.pri   = 2'($urandom);
`ifdef PIF_REG_SLICE_ROUTE_ID_EN
    r.route = 4'($urandom);
`else
    r.route = '0;
`endif
    return r;
  endfunction

  // Called just after a falling edge with inputs set; resolves the coming rising edge.
  task automatic tick();
    chk("req_vld", 256'(POReqValid_S), 256'(req_q.size() != 0));
    chk("rsp_vld", 256'(PIRespValid_M), 256'(rsp_q.size() != 0));
    chk("req_rdy", 256'(PIReqRdy_M), 256'(init_m && (req_q.size() != REQ_D)));
    chk("rsp_rdy", 256'(PORespRdy_S), 256'(init_m && (rsp_q.size() != RSP_D)));
    if (req_q.size() == 0) chk("req_zero", 256'(req_obs), 256'(0));
    if (rsp_q.size() == 0) chk("rsp_zero", 256'(rsp_obs), 256'(0));
    if (req_stall) chk("req_hold", 256'(req_obs), 256'(req_prev));
    if (rsp_stall) chk("rsp_hold", 256'(rsp_obs), 256'(rsp_prev));
    if (POReqValid_S && PIReqRdy_S && req_q.size() != 0)
      chk("req_data", 256'(req_obs), 256'(req_q.pop_front()));
    if (PIRespValid_M && PORespRdy_M && rsp_q.size() != 0) begin
      chk("rsp_data", 256'(rsp_obs), 256'(rsp_q.pop_front()));
      n_rsp_out++;
    end
    req_acc = POReqValid_M && PIReqRdy_M;
    rsp_acc = PIRespValid_S && PORespRdy_S;
    if (req_acc) req_q.push_back(req_in);
    if (rsp_acc) rsp_q.push_back(rsp_in);
    req_stall = POReqValid_S && !PIReqRdy_S;
    rsp_stall = PIRespValid_M && !PORespRdy_M;
    req_prev  = req_obs;
    rsp_prev  = rsp_obs;
    @(negedge CLK);
    init_m = BResetN;
  endtask

  task automatic idle_inputs();
    POReqValid_M  = 1'b0;
    PIRespValid_S = 1'b0;
    req_in = '0;
    rsp_in = '0;
  endtask

  initial begin
    total = 0; bad = 0; n_rsp_out = 0;
    req_stall = 0; rsp_stall = 0; req_acc = 0; rsp_acc = 0; init_m = 0;
    idle_inputs();
    PIReqRdy_S = 1'b0;
    PORespRdy_M = 1'b0;
    BResetN = 1'b1;
    #1 BResetN = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_req_vld", 256'(POReqValid_S), 256'(0));
    chk("rst_rsp_vld", 256'(PIRespValid_M), 256'(0));
    chk("rst_req_rdy", 256'(PIReqRdy_M), 256'(0));
    chk("rst_rsp_rdy", 256'(PORespRdy_S), 256'(0));
    chk("rst_req_pl", 256'(req_obs), 256'(0));
    chk("rst_rsp_pl", 256'(rsp_obs), 256'(0));
    BResetN = 1'b1;
    tick();
    chk("rdy_after_rst", 256'(PIReqRdy_M), 256'(1));

    // Single request, fields bit-exact one cycle after push
    req_in = '0;
    req_in.adrs = 32'h1000_0040;
    req_in.id   = 6'd5;
    req_in.cntl = 8'h11;
    req_in.data = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
    req_in.be   = '1;
    req_in.pri  = 2'd2;
    POReqValid_M = 1'b1;
    PIReqRdy_S   = 1'b1;
    tick();
    POReqValid_M = 1'b0;
    chk("single_vld", 256'(POReqValid_S), 256'(1));
    chk("single_adrs", 256'(POReqAdrs_S), 256'(32'h1000_0040));
    chk("single_id", 256'(POReqId_S), 256'(5));
    repeat (2) tick();

    // Five pushes into a stalled depth-4 FIFO, then drain in order
    PIReqRdy_S = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_in = rnd_req();
      req_in.data = 128'(i);
      POReqValid_M = 1'b1;
      tick();
      if (i == 3) chk("full_rdy_low", 256'(PIReqRdy_M), 256'(0));
    end
    POReqValid_M = 1'b0;
    PIReqRdy_S = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (POReqValid_S) chk("order", 256'(POReqData_S), 256'(i));
      tick();
    end

    // Full FIFO with simultaneous push and pop
    PIReqRdy_S = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_in = rnd_req();
      POReqValid_M = 1'b1;
      tick();
    end
    req_in = rnd_req();
    PIReqRdy_S = 1'b1;
    tick();
    chk("ff_rdy_next", 256'(PIReqRdy_M), 256'(1));
    chk("ff_vld", 256'(POReqValid_S), 256'(1));
    POReqValid_M = 1'b0;
    tick();
    POReqValid_M = 1'b0;
    repeat (6) tick();

    // Random traffic on both channels until 10000 responses delivered
    n_rsp_out = 0;
    req_acc = 1'b0;
    rsp_acc = 1'b0;
    for (int c = 0; c < 60000 && n_rsp_out < 10000; c++) begin
      if (!POReqValid_M || req_acc) begin
        POReqValid_M = ($urandom_range(0, 3) != 0);
        req_in = rnd_req();
      end
      if (!PIRespValid_S || rsp_acc) begin
        PIRespValid_S = ($urandom_range(0, 3) != 0);
        rsp_in = rnd_rsp();
      end
      PIReqRdy_S  = ($urandom_range(0, 3) != 0);
      PORespRdy_M = ($urandom_range(0, 3) != 0);
      tick();
    end
    chk("rsp_count", 256'(n_rsp_out >= 10000), 256'(1));
    idle_inputs();
    PIReqRdy_S = 1'b1;
    PORespRdy_M = 1'b1;
    repeat (8) tick();

    // Reset asserted with entries queued
    PIReqRdy_S = 1'b0;
    PORespRdy_M = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_in = rnd_req();
      rsp_in = rnd_rsp();
      POReqValid_M = 1'b1;
      PIRespValid_S = 1'b1;
      tick();
    end
    idle_inputs();
    #2 BResetN = 1'b0;
    #1;
    chk("arst_req_vld", 256'(POReqValid_S), 256'(0));
    chk("arst_rsp_vld", 256'(PIRespValid_M), 256'(0));
    chk("arst_req_rdy", 256'(PIReqRdy_M), 256'(0));
    chk("arst_rsp_rdy", 256'(PORespRdy_S), 256'(0));
    chk("arst_req_pl", 256'(req_obs), 256'(0));
    chk("arst_rsp_pl", 256'(rsp_obs), 256'(0));
    req_q.delete();
    rsp_q.delete();
    req_stall = 1'b0;
    rsp_stall = 1'b0;
    init_m = 1'b0;
    repeat (2) @(negedge CLK);
    PIReqRdy_S = 1'b1;
    PORespRdy_M = 1'b1;
    BResetN = 1'b1;
    tick();
    chk("rel_req_rdy", 256'(PIReqRdy_M), 256'(1));
    chk("rel_rsp_rdy", 256'(PORespRdy_S), 256'(1));
    repeat (4) tick();

`ifdef PIF_REG_SLICE_ROUTE_ID_EN
    // Route ID travels with its request and response
    req_in = rnd_req();
    rsp_in = rnd_rsp();
    req_in.route = 4'hA;
    rsp_in.route = 4'hA;
    POReqValid_M = 1'b1;
    PIRespValid_S = 1'b1;
    tick();
    idle_inputs();
    chk("route_req", 256'(POReqRouteId_S), 256'(4'hA));
    chk("route_rsp", 256'(PIRespRouteId_M), 256'(4'hA));
    repeat (3) tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
